// File: rtl/serial_add.sv
// serial_add: digit-serial unsigned adder.
// Computes c = a + b + c_in over WIDTH/DIGIT cycles, least-significant digit
// first, with the carry out of bit WIDTH-1 reported as overflow.
// Handshake: start is accepted in IDLE or DONE. busy is high while digits are
// being summed. done pulses for one cycle when c/overflow update.
module serial_add #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] c,
  output logic             overflow
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_next;

  // Operands shift right by one digit per cycle, so the active digit is
  // always the low DIGIT bits.
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  // Partial sum fills from the top. After N shifts it holds the full result.
  logic [WIDTH-1:0] psum;
  logic [WIDTH-1:0] psum_next;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic             last;
  logic [DIGIT:0]   dsum;

  // Handshake decode and the single-digit adder (DIGIT+1 bits wide)
  always_comb begin
    accept    = start && ((state == IDLE) || (state == DONE));
    last      = (state == RUN) && (cnt == CW'(N - 1));
    dsum      = {1'b0, op_a[DIGIT-1:0]}
              + {1'b0, op_b[DIGIT-1:0]}
              + {{DIGIT{1'b0}}, carry};
    psum_next = (psum >> DIGIT) | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: state_next = accept ? RUN : IDLE;
      RUN:  state_next = last ? DONE : RUN;
      DONE: state_next = accept ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Status outputs follow the state directly
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      IDLE: ;
      RUN:  busy = 1'b1;
      DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Operand capture and per-digit accumulation
  always_ff @(posedge clk) begin
    if (reset) begin
      op_a  <= '0;
      op_b  <= '0;
      psum  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else if (accept) begin
      op_a  <= a;
      op_b  <= b;
      psum  <= '0;
      carry <= c_in;
      cnt   <= '0;
    end else if (state == RUN) begin
      op_a  <= op_a >> DIGIT;
      op_b  <= op_b >> DIGIT;
      psum  <= psum_next;
      carry <= dsum[DIGIT];
      cnt   <= cnt + CW'(1);
    end
  end

  // Result registers change only at completion or reset
  always_ff @(posedge clk) begin
    if (reset) begin
      c        <= '0;
      overflow <= 1'b0;
    end else if (last) begin
      c        <= psum_next;
      overflow <= dsum[DIGIT];
    end
  end

endmodule

// File: tb/tb_serial_add.sv
// Scoreboard bench for serial_add. Stimulus pushes expected results computed
// with plain wide arithmetic. A negedge monitor checks done/busy timing and
// c/overflow every cycle against the model.
module tb_serial_add;

  localparam int WIDTH = 32;
  localparam int DIGIT = 4;
  localparam int N     = WIDTH / DIGIT;

  logic             clk   = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a     = '0;
  logic [WIDTH-1:0] b     = '0;
  logic             c_in  = 1'b0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] c;
  logic             overflow;

  serial_add #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a        (a),
    .b        (b),
    .c_in     (c_in),
    .busy     (busy),
    .done     (done),
    .c        (c),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [WIDTH-1:0] c;
    logic             ov;
    int unsigned      due;
  } exp_t;

  exp_t             q[$];
  int unsigned      m_start = 1;
  int unsigned      m_due   = 0;
  logic [WIDTH-1:0] hold_c  = '0;
  logic             hold_ov = 1'b0;
  bit               mon_en  = 1'b0;
  bit               exp_done;
  int               n_checks = 0;
  int               n_fail   = 0;

  function automatic void chk(string name, logic [WIDTH-1:0] act, logic [WIDTH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    q.delete();
    m_start = 1;
    m_due   = 0;
    hold_c  = '0;
    hold_ov = 1'b0;
    reset   = 1'b0;
    mon_en  = 1'b1;
  endtask

  // Drive start for one edge. The model decides acceptance: an edge is free
  // once it comes after the previous operation's completion edge.
  task automatic issue(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic ci);
    logic [WIDTH:0] s;
    exp_t e;
    a = x;
    b = y;
    c_in = ci;
    start = 1'b1;
    step();
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    c_in = 1'($urandom_range(0, 1));
    if (cyc > m_due) begin
      s = {1'b0, x} + {1'b0, y} + (WIDTH + 1)'(ci);
      e.c   = s[WIDTH-1:0];
      e.ov  = s[WIDTH];
      e.due = cyc + N;
      q.push_back(e);
      m_start = cyc;
      m_due   = cyc + N;
    end
  endtask

  task automatic drain();
    int unsigned n = 0;
    while (q.size() > 0 && n < 200) begin
      step();
      n++;
    end
    n_checks++;
    if (q.size() > 0) begin
      n_fail++;
      $display("FAIL drain_timeout at cycle %0d: got %0d pending expected 0 pending", cyc, q.size());
      q.delete();
    end
  endtask

  // Monitor: done must fire exactly at the model's completion cycle, busy
  // spans the run, and c/overflow hold the last completed result.
  always @(negedge clk) begin
    if (mon_en) begin
      exp_done = (q.size() > 0) && (q[0].due == cyc);
      chk("done", WIDTH'(done), WIDTH'(exp_done));
      chk("busy", WIDTH'(busy), WIDTH'((cyc >= m_start) && (cyc < m_due)));
      if (exp_done) begin
        hold_c  = q[0].c;
        hold_ov = q[0].ov;
        void'(q.pop_front());
      end
      chk("c", c, hold_c);
      chk("overflow", WIDTH'(overflow), WIDTH'(hold_ov));
    end
  end

  initial begin
    int unsigned n;
    repeat (2) step();
    do_reset();
    chk("reset_busy", WIDTH'(busy), '0);
    chk("reset_c", c, '0);

    // Directed cases
    issue(32'd5, 32'd3, 1'b0);                 drain();
    issue(32'hFFFF_FFFF, 32'd1, 1'b0);         drain();
    issue(32'h0000_000F, 32'd1, 1'b0);         drain();
    issue(32'd10, ~32'd3, 1'b1);               drain();
    issue(32'd3, ~32'd10, 1'b1);               drain();

    // Start while busy is ignored, then back-to-back issue in the DONE cycle
    issue(32'd1, 32'd2, 1'b0);
    step();
    issue(32'd100, 32'd100, 1'b0);
    n = 0;
    while (cyc < m_due && n < 50) begin
      step();
      n++;
    end
    issue(32'h8000_0000, 32'h8000_0000, 1'b0);
    chk("b2b_busy", WIDTH'(busy), WIDTH'(1));
    drain();

    // Reset four cycles into an operation aborts it
    issue(32'h1234_5678, 32'h0FED_CBA9, 1'b1);
    repeat (3) step();
    do_reset();
    chk("abort_busy", WIDTH'(busy), '0);
    chk("abort_done", WIDTH'(done), '0);
    chk("abort_c", c, '0);
    chk("abort_ovf", WIDTH'(overflow), '0);
    repeat (12) step();
    issue(32'd7, 32'd9, 1'b1);                 drain();

    // Randomized traffic with random gaps, including starts while busy
    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, N + 2)) step();
      issue($urandom, $urandom, 1'($urandom_range(0, 1)));
    end
    drain();
    repeat (2) step();

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_add.md
Name: serial_add

Overview:
- Multi-cycle, digit-serial unsigned adder. Computes c = a + b + c_in over WIDTH/DIGIT clock cycles, least-significant digit first, and reports carry-out as overflow.
- It is the addition-side companion to the combinational add/subtract datapath. Subtraction runs through it as a + ~b with c_in = 1.
- Used where a full 32-bit ripple adder in one cycle would limit clock rate or area. Issued with a start/done handshake from the ALU sequencer.

Parameters:
- WIDTH, 32, operand and result width in bits.
- DIGIT, 4, bits added per clock cycle. Must divide WIDTH; N = WIDTH/DIGIT cycles per operation.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when not busy.
- a  input  WIDTH  first operand, captured at accepted start.
- b  input  WIDTH  second operand, captured at accepted start.
- c_in  input  1  carry into bit 0, captured at accepted start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when c/overflow become valid.
- c  output  WIDTH  sum (a + b + c_in) mod 2^WIDTH.
- overflow  output  1  carry out of bit WIDTH-1 (unsigned overflow; for a + ~b + 1 this means "no borrow").

Behaviour:
- Reset: at a rising edge with reset = 1, all of the following clear:
  - state goes to IDLE;
  - busy = 0, done = 0, c = 0, overflow = 0;
  - internal operand, partial-sum, carry and digit-counter registers = 0.
- Reset has priority over start. Reset mid-operation aborts the operation: no done pulse, and c/overflow read 0.
- States are IDLE, RUN and DONE.
- IDLE:
  - start = 1 at an edge loads a, b and c_in into internal registers.
  - Clears the digit counter, sets busy = 1 and enters RUN.
  - start = 0: remain in IDLE.
- RUN:
  - Each edge adds digit k (bits k*DIGIT+DIGIT-1 .. k*DIGIT) of the operands plus the running carry.
  - The DIGIT-bit sum is written into the partial-sum register and the carry register is updated; k increments.
  - After digit N-1 is processed, the same edge does all of the following:
    - c <= partial sum and overflow <= final carry;
    - busy <= 0, done <= 1;
    - state goes to DONE.
  - start is ignored throughout RUN. Input changes during RUN have no effect.
- DONE:
  - Lasts exactly one cycle; done = 1.
  - start = 1 in this cycle is accepted, with behaviour identical to IDLE + start (back-to-back issue). done falls and busy rises on that edge.
  - Otherwise go to IDLE; done <= 0.
- Latency: with start accepted at edge E0, busy is 1 after edges E0 .. E(N-1). done and the new c/overflow appear after edge EN, i.e. N cycles later (8 for the defaults).
- Throughput is one result per N cycles with back-to-back starts.
- c and overflow change only at completion or reset. They hold the previous result through the whole next RUN; no partial values are ever visible.
- Carry propagates between digits only through the carry register. Within a digit the addition is combinational DIGIT+1 bits wide.
- DIGIT = WIDTH is legal: N = 1, and done appears one cycle after start.

Test Plan:
- a=5, b=3, c_in=0 -> c=0x00000008, overflow=0; done pulses exactly 8 cycles after start is sampled and lasts one cycle.
- a=0xFFFFFFFF, b=1, c_in=0 -> c=0x00000000, overflow=1. Also a=0x0000000F, b=1 -> c=0x00000010 (carry crosses a digit boundary), overflow=0.
- Subtraction use: a=10, b=~3 (0xFFFFFFFC), c_in=1 -> c=7, overflow=1. Then a=3, b=~10, c_in=1 -> c=0xFFFFFFF9, overflow=0.
- Start with a=1, b=2. Two cycles later, pulse start with a=100, b=100 while busy -> that start is ignored; result c=3 with done 8 cycles after the first start. Between the starts, c still holds the previous result.
- Back-to-back: assert start again in the DONE cycle with a=0x80000000, b=0x80000000 -> accepted. Second done arrives 8 cycles later with c=0, overflow=1. First result c=3 stays visible until then.
- Assert reset 4 cycles into an operation -> next cycle busy=0, done=0, c=0, overflow=0; no done pulse follows. A fresh start afterwards completes normally.
